// File: rtl/i2s_master_capture.sv
// i2s_master_capture: I2S master receiver packing 8/16-bit samples into 32-bit capture FIFO words.
// Define I2S_CAPTURE_OVERRUN_EN for a sticky overrun flag on dropped words (tied 0 otherwise).
module i2s_master_capture #(
  parameter int BCLK_DIV  = 25,
  parameter int SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        sampleSize,
  input  logic        stereoMode,
  input  logic        fifoFull,
  input  logic        sdin,
  output logic        bclk,
  output logic        wclk,
  output logic [31:0] sampleData,
  output logic        writeReq,
  output logic        overrun
);
  localparam int DW = $clog2(BCLK_DIV);
  localparam int BW = $clog2(2 * SLOT_BITS);
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t state;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt, nxt_bit, slot_bit;
  logic [15:0] shreg, smp;
  logic [31:0] pack;
  logic [1:0] pos;
  logic [4:0] nbits;
  logic size16, stereo, pend, tick, rise, fall, wrap, right, keep, last, done;
  always_comb begin
    tick = state != IDLE && div_cnt == DW'(BCLK_DIV - 1);
    rise = tick && !bclk;
    fall = tick && bclk;
    wrap = bit_cnt == BW'(2 * SLOT_BITS - 1);
    nxt_bit = wrap ? '0 : bit_cnt + 1'b1;
    right = bit_cnt >= BW'(SLOT_BITS);
    slot_bit = right ? bit_cnt - BW'(SLOT_BITS) : bit_cnt;
    nbits = size16 ? 5'd16 : 5'd8;
    keep = rise && slot_bit != '0 && slot_bit <= BW'(nbits) && (!right || stereo);
    last = keep && slot_bit == BW'(nbits);
    smp = {shreg[14:0], sdin};
    done = size16 ? pos[0] : &pos;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk <= 1'b0;
      wclk <= 1'b1;
      shreg <= '0;
      pack <= '0;
      pos <= '0;
      size16 <= 1'b0;
      stereo <= 1'b0;
      pend <= 1'b0;
      sampleData <= '0;
      writeReq <= 1'b0;
    end else begin
      writeReq <= pend && !fifoFull;
      if (pend && !fifoFull) sampleData <= pack;
      pend <= last && done;
      if (state == IDLE) begin
        bclk <= 1'b0;
        wclk <= !capture;
        div_cnt <= '0;
        bit_cnt <= '0;
        if (capture) begin
          state <= RUN;
          size16 <= sampleSize;
          stereo <= stereoMode;
          pos <= '0;
          shreg <= '0;
        end
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) bclk <= !bclk;
        // the final fall of a stopping frame leaves wclk high, its idle level
        if (fall) begin
          bit_cnt <= nxt_bit;
          wclk <= nxt_bit >= BW'(SLOT_BITS) || (state == STOP && wrap);
        end
        if (state == RUN && !capture) state <= STOP;
        else if (state == STOP && fall && wrap) state <= IDLE;
        if (keep) shreg <= smp;
        if (last) begin
          if (size16) pack[{pos[0], 4'b0} +: 16] <= smp;
          else pack[{pos, 3'b0} +: 8] <= smp[7:0];
          pos <= done ? '0 : pos + 1'b1;
        end
      end
    end
  end
`ifdef I2S_CAPTURE_OVERRUN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overrun <= 1'b0;
    else if (state == IDLE && capture) overrun <= 1'b0;
    else if (pend && fifoFull) overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif
endmodule
